tlb_flush_ctrl: RTL and testbench

//  Consumes the one-cycle SFENCE.VMA flush request from the execute-stage decoder and applies it to the TLB.

---
 rtl/tlb_flush_ctrl.sv | 154 +++++++++++++++
 tb/tb_tlb_flush_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_flush_ctrl.sv
// SFENCE.VMA flush sequencer: bulk-invalidates the TLB or walks every entry
// invalidating those that match the latched VA/ASID qualifiers.
module tlb_flush_ctrl #(
    parameter int ENTRIES = 16,
    parameter int ASID_W  = 9,
    parameter int VPN_W   = 20,
    localparam int IW     = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sfence_flush_all,
    input  logic              sfence_addr_valid,
    input  logic [31:0]       sfence_vaddr,
    input  logic              sfence_asid_valid,
    input  logic [ASID_W-1:0] sfence_asid,
    output logic [IW-1:0]     tlb_rd_idx,
    input  logic              tlb_rd_valid,
    input  logic [VPN_W-1:0]  tlb_rd_vpn,
    input  logic [ASID_W-1:0] tlb_rd_asid,
    input  logic              tlb_rd_global,
    input  logic              tlb_rd_mega,
    output logic              tlb_inv_en,
    output logic [IW-1:0]     tlb_inv_idx,
    output logic              tlb_inv_all,
    output logic              flush_busy,
    output logic              flush_done
);

    typedef struct packed {
        logic              all;
        logic              use_va;
        logic              use_asid;
        logic [VPN_W-1:0]  vpn;
        logic [ASID_W-1:0] asid;
    } req_t;

    typedef enum logic [1:0] {IDLE, INV_ALL, SCAN, DONE} state_t;

    state_t        state, state_nxt;
    req_t          cur, cur_nxt, pend, pend_nxt, inc;
    logic          pend_vld, pend_vld_nxt;
    logic [IW-1:0] k, k_nxt;
    logic          armed;
    logic          req;
    logic          va_ok, asid_ok, match;
    logic          unused_vaddr_lo;

    assign unused_vaddr_lo = ^sfence_vaddr[11:0];

    // armed stays low for the first edge after reset so a request coincident
    // with reset release is dropped.
    assign req = armed & (sfence_flush_all | sfence_addr_valid | sfence_asid_valid);

    always_comb begin
        inc          = '0;
        inc.all      = sfence_flush_all;
        inc.use_va   = sfence_addr_valid;
        inc.use_asid = sfence_asid_valid;
        inc.vpn      = sfence_vaddr[12 +: VPN_W];
        inc.asid     = sfence_asid;
    end

    // Megapage entries only carry the upper 10 VPN bits.
    assign va_ok   = !cur.use_va |
                     (tlb_rd_mega ? (cur.vpn[VPN_W-1 -: 10] == tlb_rd_vpn[VPN_W-1 -: 10])
                                  : (cur.vpn == tlb_rd_vpn));
    assign asid_ok = !cur.use_asid | (!tlb_rd_global & (cur.asid == tlb_rd_asid));
    assign match   = tlb_rd_valid & va_ok & asid_ok;

    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        k_nxt        = k;
        tlb_inv_en   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cur_nxt   = inc;
                    state_nxt = inc.all ? INV_ALL : SCAN;
                    k_nxt     = '0;
                end
            end
            INV_ALL: begin
                state_nxt = DONE;
            end
            SCAN: begin
                tlb_inv_en = match;
                if (k == IW'(ENTRIES - 1)) begin
                    state_nxt = DONE;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + IW'(1);
                end
            end
            DONE: begin
                k_nxt = '0;
                if (pend_vld) begin
                    cur_nxt      = pend;
                    state_nxt    = pend.all ? INV_ALL : SCAN;
                    pend_vld_nxt = 1'b0;
                end else if (req) begin
                    cur_nxt   = inc;
                    state_nxt = inc.all ? INV_ALL : SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Requests arriving while busy park in the single pending slot; a
        // second one widens the parked request to flush-all.
        if (req && state != IDLE) begin
            if (state == DONE) begin
                if (pend_vld) begin
                    pend_nxt     = inc;
                    pend_vld_nxt = 1'b1;
                end
            end else if (pend_vld) begin
                pend_nxt.all = 1'b1;
            end else begin
                pend_nxt     = inc;
                pend_vld_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            k        <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            pend     <= pend_nxt;
            pend_vld <= pend_vld_nxt;
            k        <= k_nxt;
            armed    <= 1'b1;
        end
    end

    assign tlb_rd_idx  = k;
    assign tlb_inv_idx = k;
    assign tlb_inv_all = (state == INV_ALL);
    assign flush_done  = (state == DONE);
    assign flush_busy  = (state != IDLE);

endmodule

// File: tb/tb_tlb_flush_ctrl.sv
// Directed bench for tlb_flush_ctrl: expected inv/done events are queued at
// stimulus time and matched by a monitor against DUT strobes.
module tb_tlb_flush_ctrl;

    localparam int ENTRIES = 16;
    localparam int ASID_W  = 9;
    localparam int VPN_W   = 20;
    localparam int IW      = 4;
    localparam int K_INV   = 0;
    localparam int K_ALL   = 1;
    localparam int K_DONE  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sfence_flush_all;
    logic              sfence_addr_valid;
    logic [31:0]       sfence_vaddr;
    logic              sfence_asid_valid;
    logic [ASID_W-1:0] sfence_asid;
    logic [IW-1:0]     tlb_rd_idx;
    logic              tlb_rd_valid;
    logic [VPN_W-1:0]  tlb_rd_vpn;
    logic [ASID_W-1:0] tlb_rd_asid;
    logic              tlb_rd_global;
    logic              tlb_rd_mega;
    logic              tlb_inv_en;
    logic [IW-1:0]     tlb_inv_idx;
    logic              tlb_inv_all;
    logic              flush_busy;
    logic              flush_done;

    logic              e_valid [ENTRIES];
    logic [VPN_W-1:0]  e_vpn   [ENTRIES];
    logic [ASID_W-1:0] e_asid  [ENTRIES];
    logic              e_g     [ENTRIES];
    logic              e_mega  [ENTRIES];

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    tlb_flush_ctrl #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .VPN_W(VPN_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sfence_flush_all  (sfence_flush_all),
        .sfence_addr_valid (sfence_addr_valid),
        .sfence_vaddr      (sfence_vaddr),
        .sfence_asid_valid (sfence_asid_valid),
        .sfence_asid       (sfence_asid),
        .tlb_rd_idx        (tlb_rd_idx),
        .tlb_rd_valid      (tlb_rd_valid),
        .tlb_rd_vpn        (tlb_rd_vpn),
        .tlb_rd_asid       (tlb_rd_asid),
        .tlb_rd_global     (tlb_rd_global),
        .tlb_rd_mega       (tlb_rd_mega),
        .tlb_inv_en        (tlb_inv_en),
        .tlb_inv_idx       (tlb_inv_idx),
        .tlb_inv_all       (tlb_inv_all),
        .flush_busy        (flush_busy),
        .flush_done        (flush_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tlb_rd_valid  = e_valid[tlb_rd_idx];
    assign tlb_rd_vpn    = e_vpn[tlb_rd_idx];
    assign tlb_rd_asid   = e_asid[tlb_rd_idx];
    assign tlb_rd_global = e_g[tlb_rd_idx];
    assign tlb_rd_mega   = e_mega[tlb_rd_idx];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic got(input int kind, input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d idx %0d expected none",
                     cyc, kind, idx);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_idx", idx, e.idx);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tlb_inv_en && tlb_inv_all) chk("inv_exclusive", 1, 0);
            if (tlb_inv_en)  got(K_INV, int'(tlb_inv_idx));
            if (tlb_inv_all) got(K_ALL, 0);
            if (flush_done)  got(K_DONE, 0);
        end
    end

    task automatic push(input int kind, input int idx, input int c);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic clear_tlb();
        for (int i = 0; i < ENTRIES; i++) begin
            e_valid[i] = 1'b0;
            e_vpn[i]   = '0;
            e_asid[i]  = '0;
            e_g[i]     = 1'b0;
            e_mega[i]  = 1'b0;
        end
    endtask

    task automatic set_e(input int i, input logic v, input logic [VPN_W-1:0] vpn,
                         input logic [ASID_W-1:0] asid, input logic g, input logic m);
        e_valid[i] = v;
        e_vpn[i]   = vpn;
        e_asid[i]  = asid;
        e_g[i]     = g;
        e_mega[i]  = m;
    endtask

    task automatic drive(input logic all, input logic av, input logic [31:0] va,
                         input logic qv, input logic [ASID_W-1:0] asid);
        sfence_flush_all  = all;
        sfence_addr_valid = av;
        sfence_vaddr      = va;
        sfence_asid_valid = qv;
        sfence_asid       = asid;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 32'h0, 1'b0, '0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (flush_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(flush_busy), 0);
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        idle_in();
        clear_tlb();
        #2;
        chk("rst_busy", int'(flush_busy), 0);
        chk("rst_done", int'(flush_done), 0);
        chk("rst_inv_all", int'(tlb_inv_all), 0);
        chk("rst_inv_en", int'(tlb_inv_en), 0);
        chk("rst_rd_idx", int'(tlb_rd_idx), 0);
        chk("rst_inv_idx", int'(tlb_inv_idx), 0);
        step(3);
        rst_n = 1'b1;
        step(3);

        // flush_all: inv_all at t+1, done at t+2, busy t+1..t+2
        drive(1'b1, 1'b0, 32'h0, 1'b0, '0);
        t = cyc;
        push(K_ALL, 0, t + 1);
        push(K_DONE, 0, t + 2);
        step(1); idle_in();
        chk("all_busy_t1", int'(flush_busy), 1);
        step(1);
        chk("all_busy_t2", int'(flush_busy), 1);
        step(1);
        chk("all_busy_t3", int'(flush_busy), 0);
        step(2);

        // VA-only: hits idx3 and the global idx7
        clear_tlb();
        set_e(3, 1'b1, 20'h40003, 9'd5, 1'b0, 1'b0);
        set_e(7, 1'b1, 20'h40003, 9'd9, 1'b1, 1'b0);
        set_e(1, 1'b1, 20'h40004, 9'd5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h4000_3000, 1'b0, '0);
        t = cyc;
        push(K_INV, 3, t + 4);
        push(K_INV, 7, t + 8);
        push(K_DONE, 0, t + 17);
        step(1); idle_in();
        wait_idle();

        // ASID-only: global and invalid entries are kept
        clear_tlb();
        set_e(2, 1'b1, 20'h11111, 9'd5, 1'b0, 1'b0);
        set_e(4, 1'b1, 20'h22222, 9'd5, 1'b1, 1'b0);
        set_e(6, 1'b0, 20'h33333, 9'd5, 1'b0, 1'b0);
        set_e(8, 1'b1, 20'h11111, 9'd6, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 9'd5);
        t = cyc;
        push(K_INV, 2, t + 3);
        push(K_DONE, 0, t + 17);
        step(1); idle_in();
        wait_idle();

        // VA+ASID with megapage compare on VPN[19:10]
        clear_tlb();
        set_e(9,  1'b1, 20'h00BFF, 9'd1, 1'b0, 1'b1);
        set_e(10, 1'b1, 20'h00BFF, 9'd1, 1'b0, 1'b0);
        set_e(11, 1'b1, 20'h00800, 9'd2, 1'b0, 1'b0);
        set_e(12, 1'b1, 20'h00800, 9'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h0080_0000, 1'b1, 9'd1);
        t = cyc;
        push(K_INV, 9, t + 10);
        push(K_INV, 12, t + 13);
        push(K_DONE, 0, t + 17);
        step(1); idle_in();
        wait_idle();

        // Three requests: 2nd parks, 3rd merges it into flush_all
        clear_tlb();
        drive(1'b0, 1'b1, 32'h1234_5000, 1'b0, '0);
        t = cyc;
        push(K_DONE, 0, t + 17);
        push(K_ALL, 0, t + 18);
        push(K_DONE, 0, t + 19);
        step(1); idle_in();
        step(2);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 9'd3);
        step(1); idle_in();
        step(1);
        drive(1'b0, 1'b1, 32'h0000_1000, 1'b0, '0);
        step(1); idle_in();
        step(12);
        chk("merge_busy_t18", int'(flush_busy), 1);
        step(2);
        chk("merge_busy_t20", int'(flush_busy), 0);
        wait_idle();

        // Reset during scan at k=5 aborts; request at release is ignored
        clear_tlb();
        set_e(0, 1'b1, 20'h40003, 9'd0, 1'b0, 1'b0);
        set_e(7, 1'b1, 20'h40003, 9'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h4000_3000, 1'b0, '0);
        t = cyc;
        push(K_INV, 0, t + 1);
        step(1); idle_in();
        step(5);
        chk("abort_rd_idx_k5", int'(tlb_rd_idx), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(flush_busy), 0);
        chk("abort_rd_idx", int'(tlb_rd_idx), 0);
        chk("abort_inv_en", int'(tlb_inv_en), 0);
        chk("abort_done", int'(flush_done), 0);
        step(2);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, '0);
        step(1); idle_in();
        step(12);
        chk("release_req_ignored", int'(flush_busy), 0);
        drive(1'b0, 1'b1, 32'h4000_3000, 1'b0, '0);
        t = cyc;
        push(K_INV, 0, t + 1);
        push(K_INV, 7, t + 8);
        push(K_DONE, 0, t + 17);
        step(1); idle_in();
        wait_idle();

        step(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
